// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders and an OR of their
// carries; this is the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder_cell u_ha0 (
        .A (A),
        .B (B),
        .S (s0),
        .C (c0)
    );

    half_adder_cell u_ha1 (
        .A (s0),
        .B (Cin),
        .S (S),
        .C (c1)
    );

    assign Cout = c0 | c1;

endmodule

// File: rtl/half_adder_cell.sv
// Single-bit half adder: the building block of the full-adder cell.
module half_adder_cell (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);

    assign S = A ^ B;
    assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flop and shift
// registers process one bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
);

    // Handshake: start is taken only on an edge in IDLE, where A/B/Cin are
    // captured; start seen in RUN or DONE is dropped. done is a one-cycle
    // pulse exactly WIDTH edges after acceptance, and SUM/Cout then hold
    // until the next completion.

    localparam int             CW   = clog2_min1(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             unused;

    full_adder_cell u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_c)
    );

    // The result register fills from the MSB; its LSB falls off each shift.
    generate
        if (WIDTH == 1) begin : g_w1
            assign r_next = fa_s;
        end else begin : g_wn
            assign r_next = {fa_s, r_sr[WIDTH-1:1]};
        end
    endgenerate

    assign unused = r_sr[0];

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= r_next;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= r_next;
                        cout_q <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SUM  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=8 instance for the main sequences
// and a WIDTH=1 instance for the exhaustive single-bit case.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         checks;
    int         errors;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .SUM   (sum8),
        .Cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .SUM   (sum1),
        .Cout  (cout1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until the 8-bit instance pulses done; scoreboards the result.
    task automatic wait_done(output int cyc, output int bcnt);
        bit         got;
        logic [8:0] e;
        cyc  = 0;
        bcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            check("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (busy8) bcnt++;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("result", {23'd0, cout8, sum8}, {23'd0, e});
        end
    endtask

    // Driver: one add on the 8-bit instance; optionally keeps start high with
    // other operands through RUN and DONE, which must be ignored.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [8:0] exp, input bit noise);
        int cyc;
        int bcnt;
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        exp_q.push_back(exp);
        tick();
        check("busy_on_accept", {31'd0, busy8}, 32'd1);
        a8   = ~a;
        b8   = ~b;
        cin8 = ~c;
        if (noise) begin
            a8 = 8'h55;
            b8 = 8'hAA;
        end else begin
            start8 = 1'b0;
        end
        wait_done(cyc, bcnt);
        check("latency", cyc, 32'd8);
        check("busy_cycles", bcnt + 1, 32'd8);
        tick();
        start8 = 1'b0;
        check("idle_busy", {31'd0, busy8}, 32'd0);
        check("idle_done", {31'd0, done8}, 32'd0);
    endtask

    initial begin
        int         cyc;
        int         bcnt;
        logic [1:0] exp1[8];
        logic [2:0] v;

        checks = 0;
        errors = 0;
        exp1   = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

        // reset with start asserted must still land in IDLE with cleared outputs
        rst    = 1'b1;
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        cin8   = 1'b1;
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8", {24'd0, sum8}, 32'd0);
        check("rst_cout8", {31'd0, cout8}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_sum1", {30'd0, cout1, sum1}, 32'd0);

        run_add(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);

        // start during RUN and DONE ignored; result holds while idle
        run_add(8'h12, 8'h34, 1'b1, 9'h047, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_busy", {31'd0, busy8}, 32'd0);
            check("hold_done", {31'd0, done8}, 32'd0);
            check("hold_result", {23'd0, cout8, sum8}, 32'h047);
        end

        // reset after three bits aborts the add without a done pulse
        a8     = 8'h3C;
        b8     = 8'h0F;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'd0);
        check("abort_cout", {31'd0, cout8}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_done", {31'd0, done8}, 32'd0);
        end
        run_add(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0);

        // start held high: back-to-back adds spaced WIDTH+2 cycles
        a8     = 8'h01;
        b8     = 8'h01;
        cin8   = 1'b0;
        start8 = 1'b1;
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h100);
        tick();
        a8 = 8'h80;
        b8 = 8'h80;
        wait_done(cyc, bcnt);
        check("b2b_latency", cyc, 32'd8);
        wait_done(cyc, bcnt);
        check("b2b_spacing", cyc, 32'd10);
        start8 = 1'b0;
        tick();
        check("b2b_idle", {30'd0, busy8, done8}, 32'd0);
        check("b2b_queue_empty", exp_q.size(), 32'd0);

        // WIDTH=1: all operand combinations
        for (int i = 0; i < 8; i++) begin
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", {30'd0, busy1, done1}, 32'd2);
            tick();
            check("w1_done", {30'd0, busy1, done1}, 32'd1);
            check("w1_result", {30'd0, cout1, sum1}, {30'd0, exp1[i]});
            tick();
            check("w1_idle", {30'd0, busy1, done1}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with carry-in; it consumes the sum/carry cell outputs one bit per clock.
- One full-adder cell is built from two half-adder cells and an OR gate. A carry flip-flop and operand/result shift registers surround it.
- It serves as the area-cheap arithmetic stage between operand registers and downstream result consumers: start pulse in, done pulse out.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- start  input  1  request to add A+B+Cin; accepted only in IDLE.
- A  input  WIDTH  operand A, sampled on the accepting edge only.
- B  input  WIDTH  operand B, sampled on the accepting edge only.
- Cin  input  1  carry-in, sampled on the accepting edge only.
- busy  output  1  high while the adder is in RUN.
- done  output  1  one-cycle pulse; SUM and Cout are valid and new.
- SUM  output  WIDTH  registered result, held until the next completion.
- Cout  output  1  registered carry-out, held until the next completion.

Behaviour:
- Reset: on any edge with rst=1 the FSM goes to IDLE. busy=0, done=0, SUM=0, Cout=0. Shift registers, carry and bit counter clear. Reset overrides start and any operation in progress. An aborted add produces no done and no SUM update.
- States:
  - IDLE: on an edge with start=1, load A_sr<=A, B_sr<=B, carry<=Cin, cnt<=0, and go to RUN. With start=0, stay in IDLE.
  - RUN: on each edge:
    - s = A_sr[0]^B_sr[0]^carry; carry <= majority(A_sr[0],B_sr[0],carry).
    - Shift A_sr and B_sr right by 1; shift s into the MSB of R_sr (R_sr shifts right).
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1, SUM <= final R_sr (including this edge's s), Cout <= new carry, and go to DONE.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - start is accepted at edge E0; busy is high from E0 to E_WIDTH; done is high from E_WIDTH to E_WIDTH+1.
  - Result is available WIDTH cycles after the accepting edge. Throughput is one add per WIDTH+2 cycles.
- Handshake:
  - start in RUN or DONE is ignored, neither queued nor latched.
  - A, B and Cin may change freely after E0 without affecting the result.
  - Holding start high continuously gives back-to-back adds, each accepted in IDLE.
- Arithmetic: {Cout,SUM} = A + B + Cin, unsigned, exact over WIDTH+1 bits; no overflow flag. Wrap-around is visible only through Cout.
- Counter: cnt width is clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts exactly one edge, then DONE.
- busy and done are never high together. done is never high in IDLE except during its own pulse cycle as defined above.

Decomposition:
- Shared package:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - A clog2 helper function for counter sizing.
- Natural sub-module full_adder_cell (A, B, Cin -> S, Cout): two half-adder cell instances with an OR of their carries. It is purely combinational, instantiated once, and is the only arithmetic in the block.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8: A=0x3C, B=0x0F, Cin=0, start one cycle -> done 8 cycles after the accepting edge, SUM=0x4B, Cout=0, busy high for exactly 8 cycles.
- WIDTH=8: A=0xFF, B=0x01, Cin=0 -> SUM=0x00, Cout=1; then A=0xFF, B=0xFF, Cin=1 -> SUM=0xFF, Cout=1.
- start pulses during RUN and during DONE with different operands -> ignored; single done; SUM is that of the first add; SUM/Cout hold value through the following idle cycles.
- rst asserted for one cycle mid-RUN (after 3 bits) -> next cycle busy=0, SUM=0, Cout=0, no done pulse. A fresh start afterwards completes correctly.
- start held high continuously, A=0x01,B=0x01 then A=0x80,B=0x80 -> done pulses spaced WIDTH+2 cycles apart; results 0x02/Cout=0, then 0x00/Cout=1.
- WIDTH=1 build: all 8 combinations of A,B,Cin -> done one cycle after acceptance; {Cout,SUM} matches the 2-bit sum in every case.
